// File: rtl/occ_rom_arbiter_pkg.sv
// Shared definitions for the rom_Occ arbiter: base codes, address width and
// the Occ byte-lane selection used when a ROM word comes back.
package occ_rom_arbiter_pkg;

  localparam int unsigned OCC_ADDR_W = 8;

  // Base codes double as the byte-lane index into a rom_Occ word.
  typedef enum logic [1:0] {
    BaseA = 2'd0,
    BaseC = 2'd1,
    BaseG = 2'd2,
    BaseT = 2'd3
  } base_e;

  // Tag carried alongside each request through the ROM access stages.
  typedef struct packed {
    logic  valid;
    logic  zero;
    base_e base;
  } occ_tag_t;

  // A=[7:0], C=[15:8], G=[23:16], T=[31:24].
  function automatic logic [7:0] occ_byte(input logic [31:0] word, input base_e base);
    logic [7:0] b;
    unique case (base)
      BaseA:   b = word[7:0];
      BaseC:   b = word[15:8];
      BaseG:   b = word[23:16];
      BaseT:   b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/occ_rom_arbiter_rr.sv
// Combinational round-robin arbiter: picks the lowest requesting index at or
// after ptr (wrapping), returning a one-hot grant and its encoded index.
module occ_rom_arbiter_rr #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  int unsigned     cand_int;
  logic [IDX_W-1:0] cand;
  logic            found;

  // Scan candidates in rotated order starting at ptr; first hit wins.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand_int = 0;
    cand     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand_int = (32'(ptr) + off) % NREQ;
      cand     = cand_int[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/occ_rom_arbiter.sv
// Shares the single-port rom_Occ between backtracking lanes. Grants one lane
// per cycle round-robin, issues k-1 to the ROM, and returns the base-selected
// Occ byte to that lane exactly three edges after acceptance.
module occ_rom_arbiter
  import occ_rom_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = OCC_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_k,
  input  logic [NREQ*2-1:0]        req_base,
  output logic [NREQ-1:0]          gnt,
  output logic                     ce_rom_Occ,
  output logic [ADDR_W-1:0]        addr_rom_Occ,
  input  logic [31:0]              data,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [7:0]               rsp_data
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0]   ptr_q, ptr_d, gnt_idx;
  logic [NREQ-1:0]   gnt_raw;
  logic              transfer;
  logic [ADDR_W-1:0] sel_k;
  base_e             sel_base;
  occ_tag_t          s1_q, s2_q, s1_d;
  logic [IdxW-1:0]   s1_id_q, s2_id_q;
  logic [NREQ-1:0]   rsp_valid_d;

  occ_rom_arbiter_rr #(
    .NREQ  (NREQ),
    .IDX_W (IdxW)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt_raw),
    .idx (gnt_idx)
  );

  // Select the winning lane's operands and form the next pointer and tag.
  always_comb begin
    gnt      = gnt_raw & {NREQ{rst_n}};
    transfer = |gnt;
    sel_k    = req_k[gnt_idx*ADDR_W +: ADDR_W];
    sel_base = base_e'(req_base[gnt_idx*2 +: 2]);
    ptr_d    = ptr_q;
    if (transfer) begin
      ptr_d = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
    s1_d = '{valid: transfer, zero: (sel_k == '0), base: sel_base};
  end

  // Decode the S2 lane id into the one-hot response strobe.
  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = s2_q.valid && (s2_id_q == IdxW'(i));
    end
  end

  // Pointer, ROM issue registers, two-stage tag pipeline and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      ce_rom_Occ   <= 1'b0;
      addr_rom_Occ <= '0;
      s1_q         <= '0;
      s1_id_q      <= '0;
      s2_q         <= '0;
      s2_id_q      <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      // k == 0 means Occ(-1) = 0: skip the ROM but keep the slot for ordering.
      ce_rom_Occ <= transfer && (sel_k != '0);
      if (transfer) begin
        addr_rom_Occ <= (sel_k != '0) ? sel_k - ADDR_W'(1) : '0;
      end
      s1_q      <= s1_d;
      s1_id_q   <= gnt_idx;
      s2_q      <= s1_q;
      s2_id_q   <= s1_id_q;
      rsp_valid <= rsp_valid_d;
      if (s2_q.valid) begin
        rsp_data <= s2_q.zero ? 8'h00 : occ_byte(data, s2_q.base);
      end
    end
  end

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Self-checking bench for occ_rom_arbiter: directed scenarios followed by
// random lane traffic, checked cycle by cycle against a cycle-indexed model.
module tb_occ_rom_arbiter;

  localparam int NREQ = 4;
  localparam int ADDR_W = 8;
  localparam int NCYC = 1024;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_k;
  logic [NREQ*2-1:0]      req_base;
  logic [NREQ-1:0]        gnt;
  logic                   ce_rom_Occ;
  logic [ADDR_W-1:0]      addr_rom_Occ;
  logic [31:0]            data;
  logic [NREQ-1:0]        rsp_valid;
  logic [7:0]             rsp_data;

  occ_rom_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_k        (req_k),
    .req_base     (req_base),
    .gnt          (gnt),
    .ce_rom_Occ   (ce_rom_Occ),
    .addr_rom_Occ (addr_rom_Occ),
    .data         (data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data)
  );

  always #5 clk = ~clk;

  // Behavioural rom_Occ: one-cycle read latency when enabled.
  logic [31:0] rom [256];
  always @(posedge clk) if (ce_rom_Occ) data <= rom[addr_rom_Occ];

  // Lane-side request state.
  logic [NREQ-1:0] lreq;
  logic [7:0]      lk [NREQ];
  logic [1:0]      lb [NREQ];

  always_comb begin
    req      = lreq;
    req_k    = '0;
    req_base = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_k[i*ADDR_W +: ADDR_W] = lk[i];
      req_base[i*2 +: 2]        = lb[i];
    end
  end

  // Model state and per-cycle expectations.
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  logic [7:0] m_addr = '0;
  int         last_lane;
  logic       e_ce   [NCYC];
  logic [7:0] e_addr [NCYC];
  logic [3:0] e_rv   [NCYC];
  logic [7:0] e_rd   [NCYC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Round-robin from the rules: first requesting lane at or after p.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (r[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  // Check the current cycle at negedge+1, then advance the model at posedge.
  task automatic step();
    int          l;
    logic [3:0]  eg;
    logic [31:0] w;
    #1;
    l  = pick(lreq, m_ptr);
    eg = (l >= 0) ? 4'(1 << l) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("ce_rom_Occ", 32'(ce_rom_Occ), 32'(e_ce[cyc]));
    chk("addr_rom_Occ", 32'(addr_rom_Occ), 32'(e_addr[cyc]));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[cyc]));
    if (e_rv[cyc] != 4'b0000) chk("rsp_data", 32'(rsp_data), 32'(e_rd[cyc]));
    @(posedge clk);
    last_lane = l;
    if (l >= 0) begin
      m_ptr = (l + 1) % NREQ;
      if (lk[l] != 8'd0) begin
        m_addr = lk[l] - 8'd1;
        e_ce[cyc+1] = 1'b1;
        w = rom[m_addr] >> (8 * lb[l]);
        e_rd[cyc+3] = w[7:0];
      end else begin
        m_addr = 8'd0;
        e_ce[cyc+1] = 1'b0;
        e_rd[cyc+3] = 8'h00;
      end
      e_rv[cyc+3] = 4'(1 << l);
    end else begin
      e_ce[cyc+1] = 1'b0;
    end
    e_addr[cyc+1] = m_addr;
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle: outputs clear at once, in-flight work drops.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ce", 32'(ce_rom_Occ), 32'd0);
    chk("rst_addr", 32'(addr_rom_Occ), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    m_ptr  = 0;
    m_addr = '0;
    for (int c = cyc; c < NCYC; c++) begin
      e_ce[c] = 1'b0; e_addr[c] = '0; e_rv[c] = '0; e_rd[c] = '0;
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] k, input logic [1:0] b);
    lk[i] = k;
    lb[i] = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = $urandom;
    rom[4]   = 32'h0A0B0C0D;
    rom[254] = {rom[254][31:24], 8'hFE, rom[254][15:0]};
    for (int c = 0; c < NCYC; c++) begin
      e_ce[c] = 1'b0; e_addr[c] = '0; e_rv[c] = '0; e_rd[c] = '0;
    end
    for (int i = 0; i < NREQ; i++) set_lane(i, 8'd1, 2'd0);

    // Reset with all lanes requesting: gnt must stay 0.
    lreq = 4'b1111;
    @(negedge clk);
    do_reset();
    lreq = 4'b0000;
    idle(2);

    // Lane 0, k=5, base C -> addr 4, byte 8'h0C.
    set_lane(0, 8'd5, 2'd1);
    lreq = 4'b0001;
    step();
    lreq = 4'b0000;
    idle(4);

    // All lanes continuous, k=1..4, base T.
    for (int i = 0; i < NREQ; i++) set_lane(i, 8'(i + 1), 2'd3);
    lreq = 4'b1111;
    idle(8);
    lreq = 4'b0000;
    idle(4);

    // Lane 2, k=0: no ROM access, zero response.
    set_lane(2, 8'd0, 2'd0);
    lreq = 4'b0100;
    step();
    lreq = 4'b0000;
    idle(4);

    // Move ptr to 2, then lanes 1 and 3 together: 3 first, then 1.
    set_lane(1, 8'd17, 2'd2);
    set_lane(3, 8'd99, 2'd1);
    lreq = 4'b0010;
    step();
    lreq = 4'b1010;
    step();
    lreq = 4'b0010;
    step();
    lreq = 4'b0000;
    idle(4);

    // Lane 0 accepted, reset in cycle 2, then grants restart at lane 0.
    set_lane(0, 8'd40, 2'd3);
    lreq = 4'b0001;
    step();
    lreq = 4'b0000;
    step();
    do_reset();
    idle(4);
    lreq = 4'b1111;
    step();
    lreq = 4'b0000;
    idle(4);

    // k=255, base G -> addr 254, byte 8'hFE.
    set_lane(3, 8'd255, 2'd2);
    lreq = 4'b1000;
    step();
    lreq = 4'b0000;
    idle(4);

    // Random traffic; a lane only changes operands when idle or just accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!lreq[i] && ($urandom_range(0, 1) == 1)) begin
          lreq[i] = 1'b1;
          case ($urandom_range(0, 7))
            0:       lk[i] = 8'd0;
            1:       lk[i] = 8'd255;
            default: lk[i] = 8'($urandom);
          endcase
          lb[i] = 2'($urandom);
        end
      end
      step();
      if (last_lane >= 0) begin
        lreq[last_lane] = 1'($urandom_range(0, 1));
        lk[last_lane]   = 8'($urandom);
        lb[last_lane]   = 2'($urandom);
      end
    end
    lreq = 4'b0000;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
